// File: rtl/sd_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sd_arb_pkg
// Description : Shared types and constants for the SD sector arbiter.
//               Holds the arbiter state encoding and the fixed client slot
//               numbers (the slot number is also the SD image index).
// Revision    : 1.0 - initial release
// ============================================================================
package sd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        XFER    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam int CL_FDD0 = 0;
    localparam int CL_FDD1 = 1;
    localparam int CL_SCSI = 2;

endpackage
`default_nettype wire

// File: rtl/sd_sector_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Returns the first set bit
//               of i_pending at or after i_ptr, wrapping modulo NCLIENT.
// Ports       : i_pending  request vector
//               i_ptr      index where the search starts (< NCLIENT)
//               o_grant    selected index (0 when nothing is pending)
//               o_valid    at least one bit of i_pending is set
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NCLIENT = 3,
    parameter int IW      = 2
) (
    input  logic [NCLIENT-1:0] i_pending,
    input  logic [IW-1:0]      i_ptr,
    output logic [IW-1:0]      o_grant,
    output logic               o_valid
);

    logic [IW:0] w_idx;

    // Walk the offsets from farthest to nearest so the nearest pending
    // client (smallest offset from the pointer) is the one left standing.
    always_comb begin
        o_grant = '0;
        o_valid = 1'b0;
        w_idx   = '0;
        for (int k = NCLIENT - 1; k >= 0; k--) begin
            w_idx = {1'b0, i_ptr} + (IW+1)'(k);
            if (w_idx >= (IW+1)'(NCLIENT)) begin
                w_idx = w_idx - (IW+1)'(NCLIENT);
            end
            if (i_pending[w_idx[IW-1:0]]) begin
                o_grant = w_idx[IW-1:0];
                o_valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sd_sector_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sd_sector_arbiter
// Description : Shares one SD-host sector port between NCLIENT requesters
//               (floppy 0, floppy 1, SCSI). Each client sees a private
//               floppy-style rd/wr + lba + busy + data_en interface; one
//               sector transaction is in flight at a time, served round-robin.
// Ports       : clk, rst                 clock, synchronous active-high reset
//               cl_rd/cl_wr/cl_lba/cl_din per-client request, address, wr data
//               cl_busy/cl_data_en/cl_err per-client status and read strobe
//               cl_addr/cl_dout           broadcast byte index / read byte
//               sd_lba/sd_rd/sd_wr        request to SD host (one-hot slot)
//               sd_ack/sd_buff_*          SD host handshake and byte stream
// Revision    : 1.0 - initial release
// ============================================================================
module sd_sector_arbiter
    import sd_arb_pkg::*;
#(
    parameter int          NCLIENT = 3,
    parameter logic [23:0] TIMEOUT = 24'd12000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCLIENT-1:0]     cl_rd,
    input  logic [NCLIENT-1:0]     cl_wr,
    input  logic [32*NCLIENT-1:0]  cl_lba,
    input  logic [8*NCLIENT-1:0]   cl_din,
    output logic [NCLIENT-1:0]     cl_busy,
    output logic [NCLIENT-1:0]     cl_data_en,
    output logic [8:0]             cl_addr,
    output logic [7:0]             cl_dout,
    output logic [NCLIENT-1:0]     cl_err,
    output logic [31:0]            sd_lba,
    output logic [NCLIENT-1:0]     sd_rd,
    output logic [NCLIENT-1:0]     sd_wr,
    input  logic                   sd_ack,
    input  logic [8:0]             sd_buff_addr,
    input  logic [7:0]             sd_buff_dout,
    input  logic                   sd_buff_wr,
    output logic [7:0]             sd_buff_din
);

    localparam int          IW         = (NCLIENT > 1) ? $clog2(NCLIENT) : 1;
    localparam logic [23:0] C_TMO_LAST = TIMEOUT - 24'd1;

    state_t              r_state;
    logic [NCLIENT-1:0]  r_pending;
    logic [NCLIENT-1:0]  r_dir;
    logic [31:0]         r_lba [NCLIENT];
    logic [IW-1:0]       r_grant;
    logic [IW-1:0]       r_ptr;
    logic [23:0]         r_timer;
    logic [NCLIENT-1:0]  r_sd_rd;
    logic [NCLIENT-1:0]  r_sd_wr;
    logic [31:0]         r_sd_lba;
    logic [NCLIENT-1:0]  r_cl_err;

    logic [IW-1:0]       w_pick;
    logic                w_pick_valid;
    logic [NCLIENT-1:0]  w_pick_oh;
    logic [NCLIENT-1:0]  w_grant_oh;
    logic [NCLIENT-1:0]  w_block;
    logic [NCLIENT-1:0]  w_capture;
    logic [NCLIENT-1:0]  w_taken;
    logic [NCLIENT-1:0]  w_pending_nxt;
    logic                w_grant_now;

    rr_pick #(
        .NCLIENT (NCLIENT),
        .IW      (IW)
    ) u_pick (
        .i_pending (r_pending),
        .i_ptr     (r_ptr),
        .o_grant   (w_pick),
        .o_valid   (w_pick_valid)
    );

    assign w_pick_oh   = NCLIENT'(1) << w_pick;
    assign w_grant_oh  = NCLIENT'(1) << r_grant;
    assign w_grant_now = (r_state == IDLE) && w_pick_valid;

    // The client being granted this cycle, or holding the port, must not
    // re-capture: a floppy holding rd as a level until busy rises would
    // otherwise queue a second transaction for the same sector.
    assign w_block       = (r_state != IDLE) ? w_grant_oh :
                           (w_grant_now ? w_pick_oh : '0);
    assign w_capture     = (cl_rd | cl_wr) & ~w_block;
    assign w_taken       = w_grant_now ? w_pick_oh : '0;
    assign w_pending_nxt = (r_pending & ~w_taken) | w_capture;

    generate
        for (genvar i = 0; i < NCLIENT; i++) begin : g_capture
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_dir[i] <= 1'b0;
                    r_lba[i] <= '0;
                end else if (w_capture[i]) begin
                    r_dir[i] <= cl_wr[i];   // write wins when both are raised
                    r_lba[i] <= cl_lba[32*i +: 32];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_grant   <= '0;
            r_ptr     <= '0;
            r_timer   <= '0;
            r_sd_rd   <= '0;
            r_sd_wr   <= '0;
            r_sd_lba  <= '0;
            r_cl_err  <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            r_cl_err  <= '0;
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_grant  <= w_pick;
                        r_sd_lba <= r_lba[w_pick];
                        if (r_dir[w_pick]) begin
                            r_sd_wr <= w_pick_oh;
                        end else begin
                            r_sd_rd <= w_pick_oh;
                        end
                        r_timer <= '0;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (sd_ack) begin
                        r_sd_rd <= '0;
                        r_sd_wr <= '0;
                        r_state <= XFER;
                    end else if (r_timer == C_TMO_LAST) begin
                        r_sd_rd  <= '0;
                        r_sd_wr  <= '0;
                        r_cl_err <= w_grant_oh;
                        r_state  <= RELEASE;
                    end else begin
                        r_timer <= r_timer + 24'd1;
                    end
                end
                XFER: begin
                    if (!sd_ack) begin
                        r_state <= RELEASE;
                    end
                end
                RELEASE: begin
                    // Advancing past the last winner is what enforces fairness.
                    r_ptr   <= (r_grant == IW'(NCLIENT - 1)) ? '0 : r_grant + 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Byte path is combinational so the client sees the SD host's strobe in
    // the same cycle it arrives.
    always_comb begin
        sd_buff_din = '0;
        for (int i = 0; i < NCLIENT; i++) begin
            if (r_grant == IW'(i)) begin
                sd_buff_din = cl_din[8*i +: 8];
            end
        end
    end

    assign cl_data_en = ((r_state == XFER) && sd_buff_wr) ? w_grant_oh : '0;
    assign cl_busy    = r_pending | ((r_state != IDLE) ? w_grant_oh : '0);
    assign cl_addr    = sd_buff_addr;
    assign cl_dout    = sd_buff_dout;
    assign cl_err     = r_cl_err;
    assign sd_rd      = r_sd_rd;
    assign sd_wr      = r_sd_wr;
    assign sd_lba     = r_sd_lba;

endmodule
`default_nettype wire
